dmem_arbiter: RTL and testbench

- Shares the single data memory (DMEM) port between two requesters: the core load/store path (port C) and a debug/DMA master (port D).
- Round-robin arbitration; one outstanding access at a time.
- Supports variable-latency memory via a ready handshake, with a timeout.
- Stalls the core PC while a core access is pending.
- Sits between the core datapath (ALU address, rs2 store data, funct3 size) and DMEM.

---
 rtl/dmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one DMEM port between the core and a debug/DMA master
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  // core load/store port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  output logic              c_stall,

  // debug / DMA port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  // data memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       OWNER_C  = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q,  state_d;
  logic              owner_q,  owner_d;
  logic              last_q,   last_d;
  logic              we_q,     we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;
  logic              gnt_q,    gnt_d;
  logic [7:0]        cnt_q,    cnt_d;

  logic              pick;
  logic              sel_we;
  logic [2:0]        sel_funct3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;

  logic              in_access;
  logic              in_done;

  // Winner for an IDLE cycle: a lone requester wins, a tie goes to whoever did not win last.
  // The winner's fields are muxed here so the alignment check sees exactly what gets latched.
  always_comb begin
    pick = OWNER_C;
    if (c_req && d_req) begin
      pick = ~last_q;
    end else if (d_req) begin
      pick = OWNER_D;
    end

    sel_we     = (pick == OWNER_D) ? d_we     : c_we;
    sel_funct3 = (pick == OWNER_D) ? d_funct3 : c_funct3;
    sel_addr   = (pick == OWNER_D) ? d_addr   : c_addr;
    sel_wdata  = (pick == OWNER_D) ? d_wdata  : c_wdata;

    // funct3[1:0] encodes size: 10 word, 01 half, 00 byte (bit 2 is only the sign choice)
    misaligned = 1'b0;
    case (sel_funct3[1:0])
      2'b10:   misaligned = |sel_addr[1:0];
      2'b01:   misaligned = sel_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for mem_ready or timeout in ACCESS, respond in DONE.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_d    = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          owner_d  = pick;
          we_d     = sel_we;
          funct3_d = sel_funct3;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          gnt_d    = 1'b1;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = misaligned;
          // a misaligned request never touches memory; it is answered with an error directly
          if (misaligned) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset leaves D as last winner so C takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_C;
      last_q   <= OWNER_D;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode: memory bus only carries the latched request in ACCESS, responses go to the owner only.
  always_comb begin
    in_access  = (state_q == ACCESS);
    in_done    = (state_q == DONE);

    mem_req    = in_access;
    mem_we     = in_access & we_q;
    mem_funct3 = in_access ? funct3_q : '0;
    mem_addr   = in_access ? addr_q   : '0;
    mem_wdata  = in_access ? wdata_q  : '0;

    c_gnt      = gnt_q & (owner_q == OWNER_C);
    d_gnt      = gnt_q & (owner_q == OWNER_D);

    c_rvalid   = in_done & (owner_q == OWNER_C);
    d_rvalid   = in_done & (owner_q == OWNER_D);
    c_rdata    = c_rvalid ? rdata_q : '0;
    d_rdata    = d_rvalid ? rdata_q : '0;
    c_err      = c_rvalid & err_q;
    d_err      = d_rvalid & err_q;

    // the core holds its PC from request until the response cycle, even while D owns memory
    c_stall    = c_req & ~c_rvalid;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req, c_we, d_req, d_we;
  logic [2:0]    c_funct3, d_funct3;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, c_err, c_stall;
  logic [DW-1:0] c_rdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_resp, m_last, m_port, m_we, m_err;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_age, m_waits;

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    bytes = (f3[1:0] == 2'b10) ? 4 : ((f3[1:0] == 2'b01) ? 2 : 1);
    return (a % bytes) != 0;
  endfunction

  always @(negedge clk) begin : model_cmp
    logic        e_g, e_v, e_err, e_mr;
    logic [31:0] e_rd;
    e_g = 1'b0; e_v = 1'b0; e_err = 1'b0; e_mr = 1'b0; e_rd = '0;
    if (!rst_n) begin
      m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1;
    end else if (m_busy) begin
      m_age++;
      e_g = (m_age == 1);
      if (m_resp) begin
        e_v = 1'b1; e_rd = m_rdata; e_err = m_err;
        m_busy = 1'b0; m_last = m_port;
      end else begin
        e_mr = 1'b1;
        if (mem_ready) begin
          m_rdata = m_we ? 32'd0 : mem_rdata; m_err = 1'b0; m_resp = 1'b1;
        end else begin
          m_waits++;
          if (m_waits == TO) begin m_rdata = 32'd0; m_err = 1'b1; m_resp = 1'b1; end
        end
      end
    end else if (c_req || d_req) begin
      m_port  = (c_req && d_req) ? !m_last : d_req;
      m_we    = m_port ? d_we     : c_we;
      m_f3    = m_port ? d_funct3 : c_funct3;
      m_addr  = m_port ? d_addr   : c_addr;
      m_wdata = m_port ? d_wdata  : c_wdata;
      m_busy  = 1'b1; m_age = 0; m_waits = 0;
      m_resp  = is_misaligned(m_f3, m_addr);
      m_err   = m_resp; m_rdata = 32'd0;
    end
    chk("c_port", {c_gnt, c_rvalid, c_err, c_rdata}, (m_port == 1'b0) ? {e_g, e_v, e_err, e_rd} : 35'd0);
    chk("d_port", {d_gnt, d_rvalid, d_err, d_rdata}, (m_port == 1'b1) ? {e_g, e_v, e_err, e_rd} : 35'd0);
    chk("c_stall", c_stall, c_req & ~((m_port == 1'b0) & e_v));
    chk("mem_req", mem_req, e_mr);
    if (e_mr) begin
      chk("mem_ctl", {mem_we, mem_funct3}, {m_we, m_f3});
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // ---------------- directed helpers ----------------
  logic        h_cg[32], h_dg[32], h_cv[32], h_dv[32], h_ce[32], h_de[32], h_mr[32], h_cs[32], h_mwe[32];
  logic [31:0] h_crd[32], h_drd[32], h_ma[32], h_mw[32];

  task automatic do_reset();
    c_req = 1'b0; d_req = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_c(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = w;
  endtask

  task automatic set_d(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = w;
  endtask

  // Samples n cycles into h_*[base..]; a requester told to drop releases req and scrambles its fields after gnt.
  task automatic record(input int n, input int base, input bit drop_c, input bit drop_d);
    logic gc, gd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_cg[base+i] = c_gnt;  h_dg[base+i] = d_gnt;  h_cv[base+i] = c_rvalid; h_dv[base+i] = d_rvalid;
      h_ce[base+i] = c_err;  h_de[base+i] = d_err;  h_crd[base+i] = c_rdata; h_drd[base+i] = d_rdata;
      h_mr[base+i] = mem_req; h_cs[base+i] = c_stall; h_ma[base+i] = mem_addr; h_mw[base+i] = mem_wdata;
      h_mwe[base+i] = mem_we;
      gc = c_gnt; gd = d_gnt;
      @(posedge clk); #1;
      if (drop_c && gc) begin c_req = 1'b0; c_addr = $urandom; c_wdata = $urandom; c_we = ~c_we; end
      if (drop_d && gd) begin d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
    end
  endtask

  logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic rand_c();
    set_c(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 4)], $urandom, $urandom);
  endtask

  task automatic rand_d();
    set_d(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 4)], $urandom, $urandom);
  endtask

  bit g_c, g_d, stall_mode, in_rst, all_hi;
  int cnt;

  initial begin
    c_req = 0; c_we = 0; c_funct3 = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;

    // core lw at 0x10, zero-wait memory
    do_reset();
    set_c(1'b0, 3'b010, 32'h10, 32'h0); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    record(4, 0, 1, 1);
    chk("t1_gnt_c0", h_cg[0], 1'b0);
    chk("t1_gnt_c1", h_cg[1], 1'b1);
    chk("t1_memreq", {h_mr[0], h_mr[1], h_mr[2]}, 3'b010);
    chk("t1_rvalid", {h_cv[1], h_cv[2], h_cv[3]}, 3'b010);
    chk("t1_rdata", h_crd[2], 32'hDEADBEEF);
    chk("t1_err", h_ce[2], 1'b0);
    chk("t1_stall", {h_cs[0], h_cs[1], h_cs[2]}, 3'b110);

    // simultaneous requests held back-to-back: C, D, C, D every 3 cycles
    do_reset();
    set_c(1'b0, 3'b010, 32'h100, 32'h0); set_d(1'b0, 3'b010, 32'h200, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    record(12, 0, 0, 0);
    c_req = 1'b0; d_req = 1'b0;
    chk("t2_gnt_order", {h_cg[1], h_dg[4], h_cg[7], h_dg[10]}, 4'b1111);
    cnt = 0;
    for (int i = 0; i < 12; i++) cnt += int'(h_cg[i]) + int'(h_dg[i]);
    chk("t2_gnt_count", cnt, 4);
    chk("t2_route", {h_cv[2], h_dv[2], h_dv[5], h_cv[5], h_cv[8], h_dv[11]}, 6'b101011);
    chk("t2_rdata_c", h_crd[2], 32'h0BADF00D);
    chk("t2_rdata_d_idle", h_drd[2], 32'h0);

    // misaligned sw at 0x22: error response without touching memory
    do_reset();
    set_c(1'b1, 3'b010, 32'h22, 32'hCAFEF00D); mem_ready = 1'b1;
    record(3, 0, 1, 1);
    chk("t3_no_memreq", {h_mr[0], h_mr[1], h_mr[2]}, 3'b000);
    chk("t3_gnt", h_cg[1], 1'b1);
    chk("t3_resp", {h_cv[1], h_ce[1], h_crd[1]}, {1'b1, 1'b1, 32'h0});

    // D read times out; C waits with stall high and is served in the next IDLE
    do_reset();
    set_d(1'b0, 3'b010, 32'h80, 32'h0); mem_ready = 1'b0; mem_rdata = 32'hA5A5A5A5;
    record(1, 0, 1, 1);
    set_c(1'b0, 3'b000, 32'h81, 32'h0);
    record(18, 1, 1, 1);
    mem_ready = 1'b1;
    record(4, 19, 1, 1);
    cnt = 0;
    for (int i = 0; i < 18; i++) cnt += int'(h_mr[i]);
    chk("t4_memreq_cycles", cnt, 16);
    chk("t4_memreq_edges", {h_mr[0], h_mr[1], h_mr[16], h_mr[17]}, 4'b0110);
    chk("t4_d_resp", {h_dv[17], h_de[17], h_drd[17]}, {1'b1, 1'b1, 32'h0});
    all_hi = 1'b1;
    for (int i = 1; i <= 19; i++) all_hi &= h_cs[i];
    chk("t4_stall", all_hi, 1'b1);
    chk("t4_c_gnt", {h_cg[18], h_cg[19]}, 2'b01);
    chk("t4_c_resp", h_cv[20], 1'b1);

    // C store with ready on the 4th ACCESS cycle; bus must stay stable while requester moves on
    do_reset();
    set_c(1'b1, 3'b010, 32'h40, 32'h12345678); mem_ready = 1'b0; mem_rdata = 32'hFFFF0000;
    record(4, 0, 1, 1);
    mem_ready = 1'b1;
    record(3, 4, 1, 1);
    all_hi = 1'b1;
    for (int i = 1; i <= 4; i++)
      all_hi &= h_mr[i] & h_mwe[i] & (h_ma[i] == 32'h40) & (h_mw[i] == 32'h12345678);
    chk("t5_bus_stable", all_hi, 1'b1);
    chk("t5_memreq_end", h_mr[5], 1'b0);
    chk("t5_resp", {h_cv[5], h_ce[5], h_crd[5]}, {1'b1, 1'b0, 32'h0});

    // reset during the second ACCESS cycle abandons the access
    do_reset();
    set_c(1'b0, 3'b010, 32'h10, 32'h0); mem_ready = 1'b0;
    record(2, 0, 0, 0);
    chk("t6_memreq_before", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_memreq_async", mem_req, 1'b0);
    chk("t6_rvalid_in_reset", {c_rvalid, d_rvalid}, 2'b00);
    set_d(1'b0, 3'b010, 32'h20, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    record(3, 0, 1, 1);
    chk("t6_no_stale_rvalid", h_cv[0], 1'b0);
    chk("t6_tie_to_c", {h_cg[1], h_dg[1]}, 2'b10);

    // randomized traffic with wait states, timeout stretches and occasional resets
    do_reset();
    stall_mode = 1'b0; in_rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      g_c = c_gnt; g_d = d_gnt;
      @(posedge clk); #1;
      if (in_rst) begin rst_n = 1'b1; in_rst = 1'b0; end
      else if ($urandom_range(0, 799) == 0) begin rst_n = 1'b0; in_rst = 1'b1; end
      if (c_req) begin
        if (g_c) begin if ($urandom_range(0, 1) == 0) c_req = 1'b0; else rand_c(); end
      end else if ($urandom_range(0, 2) == 0) rand_c();
      if (d_req) begin
        if (g_d) begin if ($urandom_range(0, 1) == 0) d_req = 1'b0; else rand_d(); end
      end else if ($urandom_range(0, 2) == 0) rand_d();
      if ($urandom_range(0, 99) == 0) stall_mode = ~stall_mode;
      mem_ready = stall_mode ? 1'b0 : ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
